// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - state encoding and defaults shared by the serial arithmetic blocks
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, start/done handshake
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, diff_q, diff_shift;
  logic [CW-1:0]    cnt;
  logic             br, bout_q;
  logic             accept, last_slice;
  logic             d, bn;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .diff (d),
    .bout (bn)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST) begin
          last_slice = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // New bit enters at the MSB so bit 0 of the result lands at diff[0] after WIDTH shifts.
  always_comb begin
    diff_shift            = diff_q >> 1;
    diff_shift[WIDTH-1]   = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sa     <= a;
        sb     <= b;
        br     <= bin;
        cnt    <= '0;
        diff_q <= '0;
        bout_q <= 1'b0;
      end else if (state == S_RUN) begin
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        br     <= bn;
        cnt    <= cnt + CW'(1);
        diff_q <= diff_shift;
        if (last_slice) bout_q <= bn;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
